cycle_sequencer: RTL and testbench
==================================

# cycle_sequencer

Multi-cycle instruction sequencer for the picoMIPS core. It generates the one-hot `cycle` phase vector consumed by the program counter, decoder and register file. It inserts wait states for slow program memory and for long-latency (multiply) instructions, and implements run/halt/single-step control. It sits between the debug/control inputs and every block that qualifies its updates on `cycle`. The PC advances only on the single `CYCLE_EXEC` cycle this block emits per instruction.

## Interface
Parameters:
- `LONG_LATENCY`, default 4: total execute cycles for a long op, including the final commit cycle. Legal range is 2..16.
- `COUNT_WIDTH`, default 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `n_reset`  in  1  asynchronous, active-low reset.
- `run`  in  1  free-run enable; level, rising edge starts from HALTED.
- `step`  in  1  single-step request; 1-cycle pulse, honoured only in HALTED.
- `mem_ready`  in  1  program memory word valid; sampled in FETCH.
- `long_op`  in  1  decoded instruction is multi-cycle; sampled in DECODE.
- `halt_req`  in  1  decoded HALT instruction; sampled in DECODE.
- `cycle`  out  `CYCLE_SIZE`  one-hot phase vector (FETCH/DECODE/EXEC bits); all-zero when halted or waiting in execute.
- `halted`  out  1  sequencer is in HALTED.
- `busy`  out  1  long-op execute wait in progress.
- `retired`  out  `COUNT_WIDTH`  instructions committed since reset; wraps.

## Operation
States: HALTED, FETCH, DECODE, EXEC_WAIT, EXEC.

Reset (`n_reset`=0) forces the following, immediately and asynchronously:
- state HALTED
- `cycle`='0, `halted`=1, `busy`=0, `retired`=0
- wait counter 0
- `run_q`=0, `step_mode`=0, `halt_pend`=0

Transitions:
- HALTED:
  - `run` & ~`run_q` → FETCH, with `step_mode`=0.
  - Otherwise `step` → FETCH, with `step_mode`=1.
  - If both are true, run wins.
  - Otherwise stay.
- FETCH: `cycle[CYCLE_FETCH]`=1. If `mem_ready` → DECODE, else stay. There is no timeout.
- DECODE: `cycle[CYCLE_DECODE]`=1.
  - Latch `halt_pend` ← `halt_req`.
  - If `long_op`: go to EXEC_WAIT and load counter ← `LONG_LATENCY`-1.
  - Otherwise go to EXEC.
- EXEC_WAIT: `cycle`='0, `busy`=1. Decrement the counter; when counter==1 → EXEC.
- EXEC: `cycle[CYCLE_EXEC]`=1 for exactly one cycle; `retired` increments, modulo 2^`COUNT_WIDTH`.
  - If `halt_pend` | `step_mode` | ~`run` → HALTED, clearing `halt_pend` and `step_mode`.
  - Otherwise → FETCH.

Other rules:
- `run_q` registers `run` every cycle. Consequently, after a HALT instruction with `run` held high, restart requires `run` to fall and rise again, or a `step`.
- Dropping `run` mid-instruction never aborts. The current instruction completes through EXEC and then halts.
- `step` outside HALTED is ignored, not queued.
- `halt_req`/`long_op` outside DECODE are ignored.
- `cycle` is always one-hot or zero, never multi-hot.
- Reset asserted mid-instruction abandons the instruction with no EXEC pulse and no `retired` increment.

## Timing
- All outputs are registered (Moore); there is no combinational input→output path.
- First FETCH appears one cycle after the edge that samples a run rising edge in HALTED.
- Short instruction, `mem_ready`=1 throughout: 3 cycles (F, D, E).
- Long instruction: 2 + `LONG_LATENCY` cycles, i.e. 6 at the default.
- Each FETCH cycle with `mem_ready`=0 adds one cycle.
- Back-to-back instructions: the FETCH of instruction N+1 is the cycle immediately after the EXEC of N.
- `halted` rises in the cycle after the final EXEC.

## Structure
- Cycle bit indices (`CYCLE_FETCH`, `CYCLE_DECODE`, `CYCLE_EXEC`) and `CYCLE_SIZE` already live in `constants.sv`.
- Add the sequencer state enum `seq_state_t` there so the decoder and testbench share it.
- One natural sub-module: `wait_counter`, a loadable down-counter with an `==1` flag, for the EXEC_WAIT countdown.
- The `retired` counter stays inline.

## Test plan
- Reset release with `run`=1, `mem_ready`=1, `long_op`=0 for 3 instructions → `cycle` sequence F,D,E,F,D,E,F,D,E starting one cycle after release; `retired`=3; `halted`=0.
- `long_op`=1 in DECODE with `LONG_LATENCY`=4 → D, then 3 cycles of `cycle`=0 with `busy`=1, then a single E; total 6 cycles.
- `mem_ready`=0 for 2 cycles in FETCH → FETCH held 3 cycles, then D,E; exactly one EXEC pulse.
- `halt_req`=1 in DECODE with `run` held 1 → after E, HALTED with `halted`=1; stays halted.
  - One `step` pulse → exactly one F,D,E, then HALTED again.
  - `run` toggled 0→1 → free-running resumes.
- `run` dropped during EXEC_WAIT → wait completes, E asserted once, then HALTED.
- `n_reset` pulsed low during DECODE → `cycle`=0 and `retired`=0 immediately; no EXEC pulse is emitted.

Source files
------------

// File: rtl/cycle_sequencer_pkg.sv
// Shared constants for the picoMIPS cycle sequencer: phase-vector bit indices,
// the sequencer state encoding and the wait-counter width.
package cycle_sequencer_pkg;

    localparam int CYCLE_SIZE   = 3;
    localparam int CYCLE_FETCH  = 0;
    localparam int CYCLE_DECODE = 1;
    localparam int CYCLE_EXEC   = 2;

    // Wide enough for LONG_LATENCY-1 with LONG_LATENCY up to 16.
    localparam int WAIT_W = 4;

    typedef enum logic [2:0] {
        SEQ_HALTED    = 3'd0,
        SEQ_FETCH     = 3'd1,
        SEQ_DECODE    = 3'd2,
        SEQ_EXEC_WAIT = 3'd3,
        SEQ_EXEC      = 3'd4
    } seq_state_t;

    function automatic logic [CYCLE_SIZE-1:0] cycle_of(input seq_state_t s);
        logic [CYCLE_SIZE-1:0] v;
        v = '0;
        case (s)
            SEQ_FETCH:  v[CYCLE_FETCH]  = 1'b1;
            SEQ_DECODE: v[CYCLE_DECODE] = 1'b1;
            SEQ_EXEC:   v[CYCLE_EXEC]   = 1'b1;
            default:    v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cycle_sequencer_wait_counter.sv
// Loadable down-counter for the long-op execute wait; flags when it reaches one.
module wait_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         is_one
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign is_one = (count_q == W'(1));

endmodule

// File: rtl/cycle_sequencer.sv
// Instruction-phase sequencer: emits the one-hot cycle vector, inserts memory and
// long-op wait states, and handles run/halt/single-step control.
module cycle_sequencer
    import cycle_sequencer_pkg::*;
#(
    parameter int LONG_LATENCY = 4,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   n_reset,
    input  logic                   run,
    input  logic                   step,
    input  logic                   mem_ready,
    input  logic                   long_op,
    input  logic                   halt_req,
    output logic [CYCLE_SIZE-1:0]  cycle,
    output logic                   halted,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] retired
);

    seq_state_t             state_q, state_d;
    logic                   run_q;
    logic                   step_mode_q, step_mode_d;
    logic                   halt_pend_q, halt_pend_d;
    logic [CYCLE_SIZE-1:0]  cycle_q, cycle_d;
    logic                   halted_q, halted_d;
    logic                   busy_q, busy_d;
    logic [COUNT_WIDTH-1:0] retired_q, retired_d;
    logic                   cnt_load, cnt_dec, cnt_one;

    wait_counter #(.W(WAIT_W)) u_wait_counter (
        .clk      (clk),
        .n_reset  (n_reset),
        .load     (cnt_load),
        .load_val (WAIT_W'(LONG_LATENCY - 1)),
        .dec      (cnt_dec),
        .is_one   (cnt_one)
    );

    always_comb begin
        state_d     = state_q;
        step_mode_d = step_mode_q;
        halt_pend_d = halt_pend_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        case (state_q)
            SEQ_HALTED: begin
                if (run && !run_q) begin
                    state_d     = SEQ_FETCH;
                    step_mode_d = 1'b0;
                end else if (step) begin
                    state_d     = SEQ_FETCH;
                    step_mode_d = 1'b1;
                end
            end
            SEQ_FETCH: begin
                if (mem_ready) begin
                    state_d = SEQ_DECODE;
                end
            end
            SEQ_DECODE: begin
                halt_pend_d = halt_req;
                if (long_op) begin
                    state_d  = SEQ_EXEC_WAIT;
                    cnt_load = 1'b1;
                end else begin
                    state_d = SEQ_EXEC;
                end
            end
            SEQ_EXEC_WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_one) begin
                    state_d = SEQ_EXEC;
                end
            end
            SEQ_EXEC: begin
                if (halt_pend_q || step_mode_q || !run) begin
                    state_d     = SEQ_HALTED;
                    halt_pend_d = 1'b0;
                    step_mode_d = 1'b0;
                end else begin
                    state_d = SEQ_FETCH;
                end
            end
            default: begin
                state_d = SEQ_HALTED;
            end
        endcase

        // Outputs are derived from the next state so they line up with state_q.
        cycle_d   = cycle_of(state_d);
        halted_d  = (state_d == SEQ_HALTED);
        busy_d    = (state_d == SEQ_EXEC_WAIT);
        retired_d = (state_d == SEQ_EXEC) ? retired_q + COUNT_WIDTH'(1) : retired_q;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= SEQ_HALTED;
            run_q       <= 1'b0;
            step_mode_q <= 1'b0;
            halt_pend_q <= 1'b0;
            cycle_q     <= '0;
            halted_q    <= 1'b1;
            busy_q      <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= run;
            step_mode_q <= step_mode_d;
            halt_pend_q <= halt_pend_d;
            cycle_q     <= cycle_d;
            halted_q    <= halted_d;
            busy_q      <= busy_d;
            retired_q   <= retired_d;
        end
    end

    assign cycle   = cycle_q;
    assign halted  = halted_q;
    assign busy    = busy_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer: free-run, long ops, memory stalls, halt,
// single step, run drop mid-instruction and asynchronous reset.
module tb_cycle_sequencer;
    import cycle_sequencer_pkg::*;

    localparam logic [2:0] C0 = 3'b000;
    localparam logic [2:0] CF = 3'b001;
    localparam logic [2:0] CD = 3'b010;
    localparam logic [2:0] CE = 3'b100;

    logic        clk;
    logic        n_reset;
    logic        run;
    logic        step;
    logic        mem_ready;
    logic        long_op;
    logic        halt_req;
    logic [2:0]  cycle;
    logic        halted;
    logic        busy;
    logic [15:0] retired;

    int passed = 0;
    int total  = 0;

    cycle_sequencer #(.LONG_LATENCY(4), .COUNT_WIDTH(16)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .run       (run),
        .step      (step),
        .mem_ready (mem_ready),
        .long_op   (long_op),
        .halt_req  (halt_req),
        .cycle     (cycle),
        .halted    (halted),
        .busy      (busy),
        .retired   (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Check phase outputs at this negedge, then advance to the next negedge.
    task automatic cyc(input string tag, input logic [2:0] ec, input logic eb, input logic eh);
        chk({tag, ".cycle"},  32'(cycle),  32'(ec));
        chk({tag, ".busy"},   32'(busy),   32'(eb));
        chk({tag, ".halted"}, 32'(halted), 32'(eh));
        @(negedge clk);
    endtask

    initial begin
        n_reset   = 1'b0;
        run       = 1'b1;
        step      = 1'b0;
        mem_ready = 1'b1;
        long_op   = 1'b0;
        halt_req  = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst.cycle",   32'(cycle),   32'(C0));
        chk("rst.halted",  32'(halted),  32'd1);
        chk("rst.busy",    32'(busy),    32'd0);
        chk("rst.retired", 32'(retired), 32'd0);

        // Free-run, three short instructions
        n_reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            cyc("run.F", CF, 1'b0, 1'b0);
            cyc("run.D", CD, 1'b0, 1'b0);
            cyc("run.E", CE, 1'b0, 1'b0);
        end
        chk("run.retired", 32'(retired), 32'd3);

        // Long op: F, D, 3 wait cycles, E
        long_op = 1'b1;
        cyc("long.F", CF, 1'b0, 1'b0);
        cyc("long.D", CD, 1'b0, 1'b0);
        long_op = 1'b0;
        cyc("long.W1", C0, 1'b1, 1'b0);
        cyc("long.W2", C0, 1'b1, 1'b0);
        cyc("long.W3", C0, 1'b1, 1'b0);
        cyc("long.E", CE, 1'b0, 1'b0);
        chk("long.retired", 32'(retired), 32'd4);

        // Memory stall: FETCH held three cycles
        mem_ready = 1'b0;
        cyc("mem.F1", CF, 1'b0, 1'b0);
        cyc("mem.F2", CF, 1'b0, 1'b0);
        mem_ready = 1'b1;
        cyc("mem.F3", CF, 1'b0, 1'b0);
        cyc("mem.D", CD, 1'b0, 1'b0);
        cyc("mem.E", CE, 1'b0, 1'b0);
        chk("mem.retired", 32'(retired), 32'd5);

        // HALT instruction with run held high
        cyc("halt.F", CF, 1'b0, 1'b0);
        halt_req = 1'b1;
        cyc("halt.D", CD, 1'b0, 1'b0);
        halt_req = 1'b0;
        cyc("halt.E", CE, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc("halt.H", C0, 1'b0, 1'b1);
        chk("halt.retired", 32'(retired), 32'd6);

        // Single step from HALTED
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        cyc("step.F", CF, 1'b0, 1'b0);
        cyc("step.D", CD, 1'b0, 1'b0);
        cyc("step.E", CE, 1'b0, 1'b0);
        cyc("step.H1", C0, 1'b0, 1'b1);
        cyc("step.H2", C0, 1'b0, 1'b1);
        chk("step.retired", 32'(retired), 32'd7);

        // Run toggled 0->1 resumes free-running
        run = 1'b0;
        @(negedge clk);
        run = 1'b1;
        cyc("resume.H", C0, 1'b0, 1'b1);
        cyc("resume.F", CF, 1'b0, 1'b0);
        cyc("resume.D", CD, 1'b0, 1'b0);
        cyc("resume.E", CE, 1'b0, 1'b0);

        // Long op with run dropped mid-wait; step during wait is ignored
        long_op = 1'b1;
        cyc("drop.F", CF, 1'b0, 1'b0);
        cyc("drop.D", CD, 1'b0, 1'b0);
        long_op = 1'b0;
        run     = 1'b0;
        cyc("drop.W1", C0, 1'b1, 1'b0);
        step    = 1'b1;
        cyc("drop.W2", C0, 1'b1, 1'b0);
        step    = 1'b0;
        cyc("drop.W3", C0, 1'b1, 1'b0);
        cyc("drop.E", CE, 1'b0, 1'b0);
        cyc("drop.H1", C0, 1'b0, 1'b1);
        cyc("drop.H2", C0, 1'b0, 1'b1);
        chk("drop.retired", 32'(retired), 32'd9);

        // Reset pulsed during DECODE
        run = 1'b1;
        cyc("rstd.H", C0, 1'b0, 1'b1);
        cyc("rstd.F", CF, 1'b0, 1'b0);
        chk("rstd.Dcycle", 32'(cycle), 32'(CD));
        #1;
        n_reset = 1'b0;
        #1;
        chk("rstd.cycle",   32'(cycle),   32'(C0));
        chk("rstd.retired", 32'(retired), 32'd0);
        chk("rstd.halted",  32'(halted),  32'd1);
        @(negedge clk);
        cyc("rstd.hold1", C0, 1'b0, 1'b1);
        cyc("rstd.hold2", C0, 1'b0, 1'b1);
        n_reset = 1'b1;
        @(negedge clk);
        cyc("rstd.F", CF, 1'b0, 1'b0);
        chk("rstd.retired2", 32'(retired), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
